// File: rtl/usram_arb.sv
// usram_arb: two-requester arbiter for the single-port usram.
// The engine has fixed priority. The host is protected by an aging counter
// that forces a host grant after HOST_MAX_WAIT consecutive denied cycles.
// The SRAM command is registered, and the read data is registered.
// A small tag pipeline routes each read response back to the requester that issued it.
module usram_arb #(
  parameter int AW            = 14,
  parameter int DW            = 64,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_req_valid,
  output logic          host_req_ready,
  input  logic          host_req_write,
  input  logic [AW-1:0] host_req_addr,
  input  logic [DW-1:0] host_req_wdata,
  output logic          host_rsp_valid,
  output logic [DW-1:0] host_rsp_rdata,
  input  logic          eng_req_valid,
  output logic          eng_req_ready,
  input  logic          eng_req_write,
  input  logic [AW-1:0] eng_req_addr,
  input  logic [DW-1:0] eng_req_wdata,
  output logic          eng_rsp_valid,
  output logic [DW-1:0] eng_rsp_rdata,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          host_starved
);

  localparam logic [7:0] MAX_WAIT = 8'(HOST_MAX_WAIT);

  logic [7:0] r_host_wait;
  logic       w_force_host;
  logic       w_gnt_host;
  logic       w_gnt_eng;
  logic       w_accept;
  logic       w_winner_write;

  // Read tag pipeline: stage 1 aligns with the SRAM command, and stage 2 aligns with sram_rdata.
  logic       r_s1_rd;
  logic       r_s1_eng;
  logic       r_s2_rd;
  logic       r_s2_eng;

  // Per-cycle grant decision. Ready depends on the valid inputs, and at most one grant is active.
  always_comb begin
    w_force_host   = host_req_valid && (r_host_wait == MAX_WAIT);
    w_gnt_host     = w_force_host || (host_req_valid && !eng_req_valid);
    w_gnt_eng      = eng_req_valid && !w_force_host;
    w_accept       = w_gnt_host || w_gnt_eng;
    w_winner_write = w_gnt_eng ? eng_req_write : host_req_write;
  end

  assign host_req_ready = w_gnt_host;
  assign eng_req_ready  = w_gnt_eng;
  assign host_starved   = (r_host_wait == MAX_WAIT);

  // Aging counter: counts consecutive denied host cycles and saturates at the force threshold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_host_wait <= 8'd0;
    end else if (!host_req_valid || w_gnt_host) begin
      r_host_wait <= 8'd0;
    end else if (r_host_wait != MAX_WAIT) begin
      r_host_wait <= r_host_wait + 8'd1;
    end
  end

  // Register the winning request onto the SRAM command bus. Address and data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_ce <= w_accept;
      if (w_gnt_eng) begin
        sram_we    <= eng_req_write;
        sram_addr  <= eng_req_addr;
        sram_wdata <= eng_req_wdata;
      end else if (w_gnt_host) begin
        sram_we    <= host_req_write;
        sram_addr  <= host_req_addr;
        sram_wdata <= host_req_wdata;
      end else begin
        sram_we <= 1'b0;
      end
    end
  end

  // Carry the read tag alongside the command so that returning data can be routed to its owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_rd  <= 1'b0;
      r_s1_eng <= 1'b0;
      r_s2_rd  <= 1'b0;
      r_s2_eng <= 1'b0;
    end else begin
      r_s1_rd  <= w_accept && !w_winner_write;
      r_s1_eng <= w_gnt_eng;
      r_s2_rd  <= r_s1_rd;
      r_s2_eng <= r_s1_eng;
    end
  end

  // Capture the SRAM read data into the owner's response register. The other port holds its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      host_rsp_valid <= 1'b0;
      host_rsp_rdata <= '0;
      eng_rsp_valid  <= 1'b0;
      eng_rsp_rdata  <= '0;
    end else begin
      host_rsp_valid <= r_s2_rd && !r_s2_eng;
      eng_rsp_valid  <= r_s2_rd && r_s2_eng;
      if (r_s2_rd && !r_s2_eng) begin
        host_rsp_rdata <= sram_rdata;
      end
      if (r_s2_rd && r_s2_eng) begin
        eng_rsp_rdata <= sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_usram_arb.sv
// tb_usram_arb: directed scoreboard bench for usram_arb with a behavioural usram.
module tb_usram_arb;
  localparam int AW = 14;
  localparam int DW = 64;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_req_valid, host_req_ready, host_req_write;
  logic [AW-1:0] host_req_addr;
  logic [DW-1:0] host_req_wdata;
  logic          host_rsp_valid;
  logic [DW-1:0] host_rsp_rdata;
  logic          eng_req_valid, eng_req_ready, eng_req_write;
  logic [AW-1:0] eng_req_addr;
  logic [DW-1:0] eng_req_wdata;
  logic          eng_rsp_valid;
  logic [DW-1:0] eng_rsp_rdata;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic          host_starved;

  usram_arb #(.AW(AW), .DW(DW), .HOST_MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_write(host_req_write), .host_req_addr(host_req_addr),
    .host_req_wdata(host_req_wdata), .host_rsp_valid(host_rsp_valid),
    .host_rsp_rdata(host_rsp_rdata),
    .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
    .eng_req_write(eng_req_write), .eng_req_addr(eng_req_addr),
    .eng_req_wdata(eng_req_wdata), .eng_rsp_valid(eng_rsp_valid),
    .eng_rsp_rdata(eng_rsp_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .host_starved(host_starved)
  );

  always #5 clk = ~clk;

  // Cycle index, which is stable between posedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port usram with 1-cycle registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q_host[$];
  exp_t q_eng[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Issue one request on either port and wait (bounded) for acceptance.
  // For a read, push the hand-computed data and its due cycle (accept + 3).
  task automatic xfer(input bit is_eng, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] exp);
    int   n;
    exp_t e;
    logic rdy;
    if (is_eng) begin
      eng_req_valid = 1'b1; eng_req_write = we; eng_req_addr = a; eng_req_wdata = d;
    end else begin
      host_req_valid = 1'b1; host_req_write = we; host_req_addr = a; host_req_wdata = d;
    end
    n = 0;
    @(negedge clk);
    rdy = is_eng ? eng_req_ready : host_req_ready;
    while (!rdy && n < 32) begin
      @(negedge clk);
      rdy = is_eng ? eng_req_ready : host_req_ready;
      n++;
    end
    chk(is_eng ? "eng_req_ready" : "host_req_ready", 64'(rdy), 64'd1);
    if (rdy && !we) begin
      e.data = exp;
      e.cyc  = cyc + 3;
      if (is_eng) q_eng.push_back(e);
      else        q_host.push_back(e);
    end
    @(posedge clk); #1;
    chk("cmd_ce", 64'(sram_ce), 64'd1);
    chk("cmd_we", 64'(sram_we), 64'(we));
    chk("cmd_addr", 64'(sram_addr), 64'(a));
    if (we) chk("cmd_wdata", sram_wdata, d);
    if (is_eng) eng_req_valid = 1'b0;
    else        host_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare whenever either port presents a response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (host_rsp_valid) begin
        if (q_host.size() == 0) chk("host_rsp_unexpected", 64'd1, 64'd0);
        else begin
          e = q_host.pop_front();
          chk("host_rsp_rdata", host_rsp_rdata, e.data);
          chk("host_rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (eng_rsp_valid) begin
        if (q_eng.size() == 0) chk("eng_rsp_unexpected", 64'd1, 64'd0);
        else begin
          e = q_eng.pop_front();
          chk("eng_rsp_rdata", eng_rsp_rdata, e.data);
          chk("eng_rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Watchdog so that the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    host_req_valid = 1'b0; host_req_write = 1'b0; host_req_addr = '0; host_req_wdata = '0;
    eng_req_valid  = 1'b0; eng_req_write  = 1'b0; eng_req_addr  = '0; eng_req_wdata  = '0;
    rst_n = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sram_ce", 64'(sram_ce), 64'd0);
    chk("rst_sram_we", 64'(sram_we), 64'd0);
    chk("rst_sram_addr", 64'(sram_addr), 64'd0);
    chk("rst_sram_wdata", sram_wdata, 64'd0);
    chk("rst_host_rsp_valid", 64'(host_rsp_valid), 64'd0);
    chk("rst_eng_rsp_valid", 64'(eng_rsp_valid), 64'd0);
    chk("rst_host_rsp_rdata", host_rsp_rdata, 64'd0);
    chk("rst_eng_rsp_rdata", eng_rsp_rdata, 64'd0);
    chk("rst_host_starved", 64'(host_starved), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Preload words 0..3 with their own index through the engine.
    for (int i = 0; i < 4; i++) xfer(1'b1, 1'b1, 14'(i), 64'(i), 64'd0);

    // Host write, then read back with 3-cycle latency.
    xfer(1'b0, 1'b1, 14'h0010, 64'h1122334455667788, 64'd0);
    xfer(1'b0, 1'b0, 14'h0010, 64'd0, 64'h1122334455667788);
    idle(6);

    // Engine back-to-back reads of 0..3.
    for (int i = 0; i < 4; i++) xfer(1'b1, 1'b0, 14'(i), 64'd0, 64'(i));
    idle(6);

    // Both valid continuously: the host is forced every 9th cycle.
    host_req_valid = 1'b1; host_req_write = 1'b1; host_req_addr = 14'h0100; host_req_wdata = 64'hA5A5;
    eng_req_valid  = 1'b1; eng_req_write  = 1'b1; eng_req_addr  = 14'h0200; eng_req_wdata  = 64'h5A5A;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      chk("arb_host_ready", 64'(host_req_ready), 64'(i % 9 == 8));
      chk("arb_eng_ready", 64'(eng_req_ready), 64'(i % 9 != 8));
      chk("arb_starved", 64'(host_starved), 64'(i % 9 == 8));
      @(posedge clk); #1;
      if (i % 9 == 8) chk("arb_forced_addr", 64'(sram_addr), 64'h0100);
    end
    host_req_valid = 1'b0; eng_req_valid = 1'b0;
    idle(2);

    // Top address: host write immediately followed by an engine read.
    xfer(1'b0, 1'b1, 14'h3FFF, 64'hDEADBEEFCAFEF00D, 64'd0);
    xfer(1'b1, 1'b0, 14'h3FFF, 64'd0, 64'hDEADBEEFCAFEF00D);
    idle(6);

    // Aging: 5 denied cycles, drop for one cycle, then 8 more denied cycles before the force.
    eng_req_valid  = 1'b1; eng_req_write  = 1'b1; eng_req_addr  = 14'h0200; eng_req_wdata  = 64'h77;
    host_req_valid = 1'b1; host_req_write = 1'b1; host_req_addr = 14'h0101; host_req_wdata = 64'h88;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("age_pre_host_ready", 64'(host_req_ready), 64'd0);
      @(posedge clk); #1;
    end
    host_req_valid = 1'b0;
    @(posedge clk); #1;
    host_req_valid = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk("age_post_host_ready", 64'(host_req_ready), 64'(j == 8));
      chk("age_post_starved", 64'(host_starved), 64'(j == 8));
      @(posedge clk); #1;
    end
    host_req_valid = 1'b0; eng_req_valid = 1'b0;
    idle(6);

    // Reset one cycle after a read accept: the response is discarded.
    host_req_valid = 1'b1; host_req_write = 1'b0; host_req_addr = 14'h0010;
    @(negedge clk);
    chk("rstmid_host_ready", 64'(host_req_ready), 64'd1);
    @(posedge clk); #1;
    host_req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rstmid_host_rsp_valid", 64'(host_rsp_valid), 64'd0);
      chk("rstmid_eng_rsp_valid", 64'(eng_rsp_valid), 64'd0);
      chk("rstmid_sram_ce", 64'(sram_ce), 64'd0);
      chk("rstmid_sram_addr", 64'(sram_addr), 64'd0);
      chk("rstmid_sram_wdata", sram_wdata, 64'd0);
      chk("rstmid_host_rsp_rdata", host_rsp_rdata, 64'd0);
      chk("rstmid_eng_rsp_rdata", eng_rsp_rdata, 64'd0);
      @(posedge clk); #1;
      if (k == 1) rst_n = 1'b1;
    end

    idle(4);
    chk("host_q_drained", 64'(q_host.size()), 64'd0);
    chk("eng_q_drained", 64'(q_eng.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
